// File: rtl/vdc_fsm_32bit_if.sv
// -----------------------------------------------------------------------------
// vdc_fsm_32bit_if
// Bundles the start/ready/done handshake, operands and result of the
// van der Corput engine.
//   start     : request, sampled only while ready=1
//   k_in      : 32-bit index, sampled on the accepting edge
//   base_sel  : 00=2, 01=3, 10=5, 11=7, sampled on the accepting edge
//   result    : Q16.16 fraction, bits [31:16] always 0
//   done      : one-cycle pulse, result valid
//   ready     : high only while the engine is idle
//   state_dbg : current FSM state (0=IDLE 1=DIGIT 2=DIV 3=DONE)
// Modports: master (requester), slave (engine).
// -----------------------------------------------------------------------------
interface vdc_fsm_32bit_if;
  logic        start;
  logic [31:0] k_in;
  logic [1:0]  base_sel;
  logic [31:0] result;
  logic        done;
  logic        ready;
  logic [1:0]  state_dbg;

  modport master (
    output start, k_in, base_sel,
    input  result, done, ready, state_dbg
  );

  modport slave (
    input  start, k_in, base_sel,
    output result, done, ready, state_dbg
  );
endinterface

// File: rtl/vdc_fsm_32bit.sv
// -----------------------------------------------------------------------------
// vdc_fsm_32bit
// Multi-cycle radical-inverse (van der Corput) engine. Converts a 32-bit index
// k into vdc(k, base) as an unsigned Q16.16 fraction in [0,1), base 2/3/5/7.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (aborts a job, no done)
//   bus : vdc_fsm_32bit_if.slave (start/k_in/base_sel in, result/done/ready/
//         state_dbg out)
//
// Handshake: a job is accepted on a rising edge where start=1 and ready=1.
// ready is high only in IDLE; start at any other time is ignored (no queue).
// done pulses for exactly one cycle when result has been updated; result
// holds until the end of the next job.
//
// Flow: DIGIT peels one base digit per cycle, building R (digit-reversed
// numerator) and D = base^N. DIV then produces floor(R*2^16/D) by restoring
// division, one quotient bit per cycle, MSB first.
//
// Optional feature, macro VDC_ROUND_EN: when defined, DIV runs one extra
// iteration and the extra LSB rounds the quotient half-up, saturating at
// 0x0000FFFF (one cycle more latency). Undefined: plain truncation.
// -----------------------------------------------------------------------------
module vdc_fsm_32bit #(
  parameter int FRAC_BITS = 16,
  parameter int ACC_W     = 36
) (
  input  logic             clk,
  input  logic             rst,
  vdc_fsm_32bit_if.slave   bus
);

`ifdef VDC_ROUND_EN
  localparam int ITER = FRAC_BITS + 1;
`else
  localparam int ITER = FRAC_BITS;
`endif
  localparam int QW    = ITER;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_DIV   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        k_q, k_d;
  logic [1:0]         base_q, base_d;
  logic [ACC_W-1:0]   r_q, r_d;
  logic [ACC_W-1:0]   d_q, d_d;
  logic [ACC_W:0]     rem_q, rem_d;
  logic [QW-1:0]      quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;

  // Combinational helpers
  logic [ACC_W-1:0]   base_w;
  logic [31:0]        digit_q;
  logic [2:0]         digit_r;
  logic [ACC_W:0]     shifted;
  logic               div_bit;
  logic [QW-1:0]      q_next;
`ifdef VDC_ROUND_EN
  logic [FRAC_BITS:0] rsum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      base_q   <= '0;
      r_q      <= '0;
      d_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      r_q      <= r_d;
      d_q      <= d_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_d   = base_q;
    r_d      = r_q;
    d_d      = d_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef VDC_ROUND_EN
    rsum     = '0;
`endif

    // Digit extraction: divide by a constant, so each arm is a fixed divider.
    case (base_q)
      2'b00: begin
        base_w  = ACC_W'(2);
        digit_q = k_q >> 1;
        digit_r = {2'b00, k_q[0]};
      end
      2'b01: begin
        base_w  = ACC_W'(3);
        digit_q = k_q / 32'd3;
        digit_r = 3'(k_q % 32'd3);
      end
      2'b10: begin
        base_w  = ACC_W'(5);
        digit_q = k_q / 32'd5;
        digit_r = 3'(k_q % 32'd5);
      end
      default: begin
        base_w  = ACC_W'(7);
        digit_q = k_q / 32'd7;
        digit_r = 3'(k_q % 32'd7);
      end
    endcase

    // Restoring-division step; rem_q < D always, so the shift cannot lose bits.
    shifted = rem_q << 1;
    div_bit = (shifted >= {1'b0, d_q});
    q_next  = (quo_q << 1) | QW'(div_bit);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          k_d     = bus.k_in;
          base_d  = bus.base_sel;
          r_d     = '0;
          d_d     = ACC_W'(1);
          state_d = S_DIGIT;
        end
      end

      S_DIGIT: begin
        if (k_q != 32'd0) begin
          k_d = digit_q;
          r_d = r_q * base_w + ACC_W'(digit_r);
          d_d = d_q * base_w;
        end else begin
          rem_d   = {1'b0, r_q};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        rem_d = div_bit ? (shifted - {1'b0, d_q}) : shifted;
        quo_d = q_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
`ifdef VDC_ROUND_EN
          // Extra LSB is the half-unit; add it and clamp at all-ones.
          rsum = {1'b0, q_next[QW-1:1]} + (FRAC_BITS + 1)'(q_next[0]);
          if (rsum[FRAC_BITS]) begin
            result_d = 32'({FRAC_BITS{1'b1}});
          end else begin
            result_d = 32'(rsum[FRAC_BITS-1:0]);
          end
`else
          result_d = 32'(q_next);
`endif
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.result    = result_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.ready     = (state_q == S_IDLE);
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_vdc_fsm_32bit.sv
// -----------------------------------------------------------------------------
// tb_vdc_fsm_32bit
// Directed bench for vdc_fsm_32bit. Expected results are hand-computed as
// floor(R*2^16/D) (or the rounded 17-bit variant when VDC_ROUND_EN is
// defined). Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vdc_fsm_32bit;

  logic clk = 1'b0;
  logic rst;

  vdc_fsm_32bit_if bus();

  vdc_fsm_32bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef VDC_ROUND_EN
  localparam int RX = 1;
`else
  localparam int RX = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // One job: start accepted at edge E, done expected at E+N+17+RX,
  // ready back at the following edge.
  task automatic run_job(input logic [31:0] k, input logic [1:0] bs,
                         input logic [31:0] exp_res, input int n_dig,
                         input string name);
    int lat;
    int done_at;
    int n_done;
    lat     = n_dig + 17 + RX;
    done_at = -1;
    n_done  = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.k_in     = k;
    bus.base_sel = bs;
    @(negedge clk);
    // Operands change after acceptance; the job must not notice.
    bus.start    = 1'b0;
    bus.k_in     = $urandom;
    bus.base_sel = 2'($urandom_range(0, 3));
    n_checks++;
    if (bus.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept_ready: got %b want 0", name, bus.ready);
    end
    for (int j = 1; j <= lat + 1; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = j;
      end
      if (j < lat) begin
        n_checks++;
        if (bus.ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy_ready at E+%0d: got %b want 0", name, j, bus.ready);
        end
      end
      if (j == lat) begin
        n_checks++;
        if (bus.result !== exp_res) begin
          n_fail++;
          $display("FAIL %s result: got %h want %h", name, bus.result, exp_res);
        end
      end
      if (j == lat + 1) begin
        n_checks++;
        if (bus.ready !== 1'b1) begin
          n_fail++;
          $display("FAIL %s ready_return: got %b want 1", name, bus.ready);
        end
      end
    end
    n_checks++;
    if (done_at != lat) begin
      n_fail++;
      $display("FAIL %s done_edge: got E+%0d want E+%0d", name, done_at, lat);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d want 1", name, n_done);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.k_in     = 32'd0;
    bus.base_sel = 2'b00;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", bus.ready);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b want 0", bus.done);
    end
    n_checks++;
    if (bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0", bus.result);
    end
    n_checks++;
    if (bus.state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", bus.state_dbg);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    // k=1 b2: R=1 D=2.   k=5 b2: R=5 D=8.   k=2 b3: R=2 D=3.
    // k=11 b7: R=29 D=49. k=3 b5: R=3 D=5.  k=7 b3: R=5 D=9.
    // k=0: R=0 D=1.      k=FFFFFFFF b2: R=2^32-1 D=2^32 (saturates when rounding).
    run_job(32'd1,  2'b00, 32'h0000_8000, 1, "k1_b2");
    run_job(32'd5,  2'b00, 32'h0000_A000, 3, "k5_b2");
    run_job(32'd2,  2'b01, RX ? 32'h0000_AAAB : 32'h0000_AAAA, 1, "k2_b3");
    run_job(32'd11, 2'b11, RX ? 32'h0000_9783 : 32'h0000_9782, 2, "k11_b7");
    run_job(32'd3,  2'b10, RX ? 32'h0000_999A : 32'h0000_9999, 1, "k3_b5");
    run_job(32'd7,  2'b01, RX ? 32'h0000_8E39 : 32'h0000_8E38, 2, "k7_b3");
    run_job(32'd0,  2'b10, 32'h0000_0000, 0, "k0_b5");
    run_job(32'd0,  2'b11, 32'h0000_0000, 0, "k0_b7");
    run_job(32'hFFFF_FFFF, 2'b00, 32'h0000_FFFF, 32, "kmax_b2");
  endtask

  // Start held high throughout a job, then accepted again the moment
  // ready rises. Previous result is 0xFFFF from the last basic job.
  task automatic test_back_to_back();
    int l1;
    int l2;
    int n_done;
    l1     = 3 + 17 + RX;
    l2     = 1 + 17 + RX;
    n_done = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.k_in     = 32'd5;
    bus.base_sel = 2'b00;
    @(negedge clk);
    // Second job operands: k=1 base 7 -> floor(65536/7) = 0x2492
    // (rounded form is identical, the extra bit is 0).
    bus.k_in     = 32'd1;
    bus.base_sel = 2'b11;
    for (int j = 1; j <= l1 + 2 + l2 + 1; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
      if (j < l1) begin
        n_checks++;
        if (bus.result !== 32'h0000_FFFF) begin
          n_fail++;
          $display("FAIL b2b_hold at E+%0d: got %h want 0000ffff", j, bus.result);
        end
      end
      if (j == l1) begin
        n_checks++;
        if (bus.done !== 1'b1 || bus.result !== 32'h0000_A000) begin
          n_fail++;
          $display("FAIL b2b_first: done %b result %h want 1 0000a000", bus.done, bus.result);
        end
      end
      if (j == l1 + 1) begin
        n_checks++;
        if (bus.ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_rise: got %b want 1", bus.ready);
        end
      end
      if (j == l1 + 2) begin
        n_checks++;
        if (bus.ready !== 1'b0 || bus.state_dbg !== 2'd1) begin
          n_fail++;
          $display("FAIL b2b_accept: ready %b state %0d want 0 1", bus.ready, bus.state_dbg);
        end
        bus.start = 1'b0;
      end
      if (j == l1 + 2 + l2) begin
        n_checks++;
        if (bus.done !== 1'b1 || bus.result !== 32'h0000_2492) begin
          n_fail++;
          $display("FAIL b2b_second: done %b result %h want 1 00002492", bus.done, bus.result);
        end
      end
    end
    n_checks++;
    if (n_done != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d want 2", n_done);
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    n_done = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.k_in     = 32'hFFFF_FFFF;
    bus.base_sel = 2'b00;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL midrst_in_digit: state %0d want 1", bus.state_dbg);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ready !== 1'b1 || bus.result !== 32'h0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: ready %b result %h done %b want 1 0 0",
               bus.ready, bus.result, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %0d want 0", n_done);
    end
    run_job(32'd1, 2'b00, 32'h0000_8000, 1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
